// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed when the operation is accepted and held in pending
// registers. It is copied to HI/LO only when the busy counter expires, so a
// cancelled operation never reaches HI/LO.
module md_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic               done_q, done_d;

    logic               busy_w;
    logic               is_signed;
    logic               a_neg, b_neg;
    logic [2*WIDTH-1:0] mul_a, mul_b, product;
    logic [WIDTH-1:0]   a_mag, b_mag, uq, ur, quot, rem;

    assign busy_w = (cnt_q != '0);

    // Operand conditioning shared by the multiplier and divider paths
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        mul_a     = {{WIDTH{a_neg}}, a};
        mul_b     = {{WIDTH{b_neg}}, b};
        product   = mul_a * mul_b;
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // Magnitude divide with sign fix-up; most-negative / -1 wraps naturally
    // to most-negative with zero remainder. Divide by zero is overridden later.
    always_comb begin
        uq   = '0;
        ur   = '0;
        if (b_mag != '0) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? -uq : uq;
        rem  = a_neg ? -ur : ur;
    end

    // Next-state: cancel beats completion beats accept
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        done_d   = 1'b0;
        if (cancel) begin
            cnt_d = '0;
        end else if (busy_w) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                hi_d   = res_hi_q;
                lo_d   = res_lo_q;
                done_d = 1'b1;
            end
        end else if (start) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    cnt_d    = CW'(MUL_CYCLES);
                    res_hi_d = product[2*WIDTH-1:WIDTH];
                    res_lo_d = product[WIDTH-1:0];
                end
                OP_DIV, OP_DIVU: begin
                    cnt_d = CW'(DIV_CYCLES);
                    if (b == '0) begin
                        res_hi_d = a;
                        res_lo_d = '1;
                    end else begin
                        res_hi_d = rem;
                        res_lo_d = quot;
                    end
                end
                OP_MTHI: hi_d = a;
                OP_MTLO: lo_d = a;
                default: ;
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_w;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed literal checks plus randomized traffic, all compared
// every cycle against a transaction-level model built on 64-bit arithmetic.
module tb_md_unit;

    localparam int W    = 32;
    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [3:0]    op;
    logic [W-1:0]  a, b;
    logic          cancel;
    logic          busy, done;
    logic [W-1:0]  hi, lo;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    md_unit #(.WIDTH(W), .MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] mdl(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            4'd1: begin p = 64'(sx * sy); return p; end
            4'd2: begin p = ux * uy; return p; end
            4'd3: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (y == 0) return {x, 32'hFFFFFFFF};
                p = ux / uy;
                ux = ux % uy;
                return {ux[31:0], p[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Model: the operation accepted at edge k0 owns the unit until edge
    // k0+N, at which edge it commits. Busy is "last edge index < m_end".
    int          m_edge = 0;
    int          m_end  = 0;
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    logic        m_done = 0;

    always @(posedge clk or negedge reset_n) begin : model
        int k;
        bit was_busy;
        logic [63:0] r;
        if (!reset_n) begin
            m_end  <= m_edge;
            m_hi   <= 0;
            m_lo   <= 0;
            p_hi   <= 0;
            p_lo   <= 0;
            m_done <= 0;
        end else begin
            k        = m_edge + 1;
            was_busy = (m_edge < m_end);
            m_edge   <= k;
            m_done   <= 0;
            if (cancel) begin
                if (was_busy) m_end <= k;
            end else if (was_busy) begin
                if (k == m_end) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1;
                end
            end else if (start) begin
                $display("accept op=%0d a=%h b=%h", op, a, b);
                if (op >= 4'd1 && op <= 4'd4) begin
                    r = mdl(op, a, b);
                    p_hi  <= r[63:32];
                    p_lo  <= r[31:0];
                    m_end <= k + ((op <= 4'd2) ? MULN : DIVN);
                end else if (op == 4'd5) begin
                    m_hi <= a;
                end else if (op == 4'd6) begin
                    m_lo <= a;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("cyc_busy", {31'd0, busy}, {31'd0, (m_edge < m_end)});
            cmp("cyc_done", {31'd0, done}, {31'd0, m_done});
            cmp("cyc_hi", hi, m_hi);
            cmp("cyc_lo", lo, m_lo);
        end
    end

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int nb);
        @(negedge clk);
        start = 1; op = o; a = x; b = y;
        @(negedge clk);
        start = 0;
        nb = 0;
        while (busy && nb < 100) begin
            nb++;
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb;
        int w;
        reset_n = 0; start = 0; cancel = 0; op = 0; a = 0; b = 0;
        repeat (2) @(negedge clk);
        cmp("rst_busy", {31'd0, busy}, 0);
        cmp("rst_done", {31'd0, done}, 0);
        cmp("rst_hi", hi, 0);
        cmp("rst_lo", lo, 0);
        reset_n = 1;
        chk_en  = 1;

        // MULT -2*3
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, nb);
        cmp("mult_busy_cycles", 32'(nb), 5);
        cmp("mult_done", {31'd0, done}, 1);
        cmp("mult_hi", hi, 32'hFFFFFFFF);
        cmp("mult_lo", lo, 32'hFFFFFFFA);
        @(negedge clk);
        cmp("mult_done_once", {31'd0, done}, 0);

        // MULTU max*max, DIV -7/2
        run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, nb);
        cmp("multu_hi", hi, 32'hFFFFFFFE);
        cmp("multu_lo", lo, 32'h00000001);
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, nb);
        cmp("div_busy_cycles", 32'(nb), 10);
        cmp("div_lo", lo, 32'hFFFFFFFD);
        cmp("div_hi", hi, 32'hFFFFFFFF);

        // Divide by zero and overflow case
        run_op(4'd4, 32'd100, 32'd0, nb);
        cmp("divu0_busy_cycles", 32'(nb), 10);
        cmp("divu0_lo", lo, 32'hFFFFFFFF);
        cmp("divu0_hi", hi, 32'd100);
        run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, nb);
        cmp("divovf_lo", lo, 32'h80000000);
        cmp("divovf_hi", hi, 32'd0);

        // Start while busy is ignored
        @(negedge clk);
        start = 1; op = 4'd3; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        start = 1; op = 4'd5; a = 32'd5;
        @(negedge clk);
        start = 0;
        w = 0;
        while (busy && w < 100) begin
            w++;
            @(negedge clk);
        end
        cmp("ign_idle_bound", {31'd0, (w < 100)}, 1);
        cmp("ign_hi", hi, 32'd6);
        cmp("ign_lo", lo, 32'd142);

        // MTHI / MTLO while idle
        @(negedge clk);
        start = 1; op = 4'd5; a = 32'h1234;
        @(negedge clk);
        start = 0;
        cmp("mthi_hi", hi, 32'h1234);
        cmp("mthi_busy", {31'd0, busy}, 0);
        cmp("mthi_done", {31'd0, done}, 0);
        start = 1; op = 4'd6; a = 32'hABCD;
        @(negedge clk);
        start = 0;
        cmp("mtlo_lo", lo, 32'hABCD);

        // Cancel on busy cycle 3
        start = 1; op = 4'd1; a = 32'd100; b = 32'd100;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        cancel = 1;
        @(negedge clk);
        cancel = 0;
        cmp("cancel_busy", {31'd0, busy}, 0);
        cmp("cancel_done", {31'd0, done}, 0);
        cmp("cancel_hi", hi, 32'h1234);
        cmp("cancel_lo", lo, 32'hABCD);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmp("cancel_no_done", {31'd0, done}, 0);
        end

        // Same-edge start+cancel while idle
        start = 1; cancel = 1; op = 4'd5; a = 32'hDEAD;
        @(negedge clk);
        start = 0; cancel = 0;
        cmp("blk_hi", hi, 32'h1234);
        cmp("blk_busy", {31'd0, busy}, 0);

        // Asynchronous reset mid-DIV
        start = 1; op = 4'd3; a = 32'd50; b = 32'd3;
        @(negedge clk);
        start = 0;
        repeat (2) @(negedge clk);
        #2 reset_n = 0;
        #1;
        cmp("arst_busy", {31'd0, busy}, 0);
        cmp("arst_done", {31'd0, done}, 0);
        cmp("arst_hi", hi, 0);
        cmp("arst_lo", lo, 0);
        @(negedge clk);
        reset_n = 1;
        run_op(4'd1, 32'd6, 32'd7, nb);
        cmp("post_rst_lo", lo, 32'd42);
        cmp("post_rst_hi", hi, 32'd0);

        // Randomized traffic
        repeat (500) begin
            @(negedge clk);
            start  = ($urandom_range(0, 1) == 1);
            op     = 4'($urandom_range(0, 8));
            a      = pick();
            b      = pick();
            cancel = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        start = 0; cancel = 0;
        repeat (15) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
